demux18_deser: RTL
==================

# demux18_deser

Registered 1-to-8 demultiplexer and serial-to-parallel deserializer: the receiving end of the 8x1 select-and-forward path. Each valid serial bit is steered into one of 8 word positions. The position comes from an internal wrapping index counter (auto mode) or from an explicit `sel` (addressed mode). When position 7 is written, the completed 8-bit word is presented behind a valid/ready handshake. The block sits downstream of any 8x1 mux whose `sel` steps 000→111, and rebuilds the original `in` word.

## Interface
- `WIDTH`, 8: word width and number of demux outputs; must be a power of 2.
- `SEL_W`, 3: index width, equal to log2(WIDTH).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous soft clear; same effect as `rst`, except `out` data is kept.
- `in`  in  1  serial data bit.
- `in_valid`  in  1  `in` is sampled this cycle.
- `auto`  in  1  1 = index from the internal counter; 0 = index from `sel`.
- `sel`  in  SEL_W  explicit target position; used only when `auto`=0.
- `out`  out  WIDTH  completed word; bit i was written at index i (LSB first).
- `out_valid`  out  1  `out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts `out` in this cycle.
- `idx`  out  SEL_W  next auto-mode index (counter value).
- `overrun`  out  1  sticky; a completed word was dropped.

## Operation
- Internal shadow register `shd[WIDTH-1:0]` collects bits. Effective index `e` = `idx` when `auto`=1, else `sel`.
- On `in_valid`: `shd[e]` ← `in`. All other shadow bits hold their values; the shadow is never auto-cleared, so in addressed mode unwritten bits keep their old contents.
- Counter update on `in_valid`:
  - auto mode: `idx` ← `idx`+1, modulo WIDTH (7→0 wraps).
  - addressed mode: `idx` ← `sel`+1, modulo WIDTH, so a later switch to auto mode continues from the next position.
  - Without `in_valid`, `idx` holds.
- Completion: `in_valid` with `e`=WIDTH-1. The completed word is `shd` with bit `e` replaced by the current `in`; no cycle is lost.
- Output handshake, evaluated each cycle. "Accepted" means `out_valid`&`out_ready`.
  - Completion with `out_valid`=0, or completion with the old word accepted in the same cycle: `out` ← word, `out_valid` ← 1, no overrun.
  - Accept without completion: `out_valid` ← 0. `out` holds its stale value.
  - Completion with `out_valid`=1 and `out_ready`=0: the new word is discarded, `out` and `out_valid` are unchanged, and `overrun` ← 1.
- `overrun` clears only on `rst` or `clr`.
- Reset values (`rst`): `out`=0, `out_valid`=0, `idx`=0, `overrun`=0, `shd`=0.
- `clr` sets `shd`, `idx`, `out_valid` and `overrun` to 0 and leaves `out` unchanged. `rst` and `clr` take priority over `in_valid` in the same cycle; that bit is dropped.
- Reset mid-word: the partial word is lost and the next bit lands at index 0.

## Timing
- Latency: completing bit sampled at edge n → `out`/`out_valid` visible after edge n (one register stage). `overrun` also updates at edge n.
- Auto-mode throughput: one word per 8 consecutive `in_valid` cycles; back-to-back words are allowed.
- `out_ready` is sampled only while `out_valid`=1; `out_ready` while `out_valid`=0 is ignored.
- No combinational path from any input to `out`, `out_valid`, `idx` or `overrun`; all outputs are registered.
- `sel` and `auto` are sampled only in cycles with `in_valid`=1 and may change freely between them.

## Structure
- Shared package `demux_pkg` holds `WIDTH`, `SEL_W`, and the localparam `LAST_IDX` = WIDTH-1.
- One sub-module, `demux_idx_ctr`: the SEL_W-bit wrapping counter with load (`sel`+1), increment, and synchronous clear. The top level holds the shadow register, completion detect and output handshake.

## Test plan
- Auto mode, `out_ready`=1, serial 1,0,1,0,1,0,1,0 on 8 consecutive cycles → one cycle after the 8th bit, `out`=8'b01010101 and `out_valid`=1 for one cycle; `idx` wraps to 0.
- Addressed mode: `sel`=7 with `in`=1 after `rst` → `out`=8'b10000000, `out_valid`=1, and `idx`=0.
- Back-to-back: two auto words 8'hA5 then 8'h3C with `out_ready`=1 → `out_valid` high on cycles 9 and 17; values 8'hA5 then 8'h3C; `overrun`=0.
- Overrun: word 8'hFF completes, `out_ready` held 0, then word 8'h00 completes → `out` stays 8'hFF and `overrun`=1. Driving `out_ready`=1 afterwards drops `out_valid`; `overrun` stays 1 until `clr`.
- Simultaneous: completion of 8'h12 in the same cycle that 8'h34 is accepted → `out`=8'h12, `out_valid` stays 1, `overrun`=0.
- `rst` asserted after 4 auto bits → `idx`=0 and `out_valid`=0. The next 8 bits 8'h81 produce `out`=8'h81; no stale bits from the partial word appear.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared sizing constants for the 1-to-8 demux / deserializer.
package demux_pkg;

  localparam int WIDTH    = 8;
  localparam int SEL_W    = 3;
  localparam int LAST_IDX = WIDTH - 1;

endpackage : demux_pkg

// File: rtl/demux_idx_ctr.sv
// Wrapping position counter: clears, loads sel+1, or increments.
// The wrap from LAST_IDX to 0 comes for free from the SEL_W-bit width.
module demux_idx_ctr
  import demux_pkg::*;
#(
  parameter int CTR_W = SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             load,
  input  logic [CTR_W-1:0] load_base,
  output logic [CTR_W-1:0] idx
);

  logic [CTR_W-1:0] idx_q;
  logic [CTR_W-1:0] idx_d;

  // Next index: a load takes priority over a plain increment.
  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = load_base + CTR_W'(1);
    end else if (inc) begin
      idx_d = idx_q + CTR_W'(1);
    end
  end

  // Counter register; both reset and soft clear return to position 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule : demux_idx_ctr

// File: rtl/demux18_deser.sv
// Receiving end of the 8x1 select-and-forward path. Serial bits are steered
// into a shadow word; writing the last position publishes the word behind a
// valid/ready handshake. A word that completes while the previous one is
// still pending is dropped and flagged with the sticky overrun bit.
module demux18_deser
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int SEL_W = demux_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in,
  input  logic             in_valid,
  input  logic             auto,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] idx,
  output logic             overrun
);

  logic [WIDTH-1:0] shd_q, shd_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic [SEL_W-1:0] e_idx;
  logic             complete;
  logic             accept;

  demux_idx_ctr #(
    .CTR_W(SEL_W)
  ) u_idx_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .inc      (in_valid && auto),
    .load     (in_valid && !auto),
    .load_base(sel),
    .idx      (idx)
  );

  // Effective write position, shadow update and completion detect.
  // shd_d already carries the incoming bit, so it doubles as the completed
  // word and the last bit costs no extra cycle.
  always_comb begin
    e_idx    = auto ? idx : sel;
    shd_d    = shd_q;
    complete = 1'b0;
    if (in_valid) begin
      shd_d[e_idx] = in;
      complete     = (e_idx == SEL_W'(LAST_IDX));
    end
  end

  // Output handshake: publish, consume, or drop-and-flag.
  always_comb begin
    accept      = out_valid_q && out_ready;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_d       = shd_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d   = 1'b1;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; soft clear keeps the last published data word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shd_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (clr) begin
      shd_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shd_q       <= shd_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule : demux18_deser
